threshold_binarizer: RTL

//  Consumes the threshold/valid pair produced by the threshold button stage and applies it to the
//  RGB565 camera pixel stream: luma per pixel, compared against the active threshold, emitted as a

---
 rtl/threshold_pkg.sv | 30 +++
 rtl/rgb565_to_luma.sv | 79 +++++++
 rtl/threshold_binarizer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/threshold_pkg.sv
// Shared types and constants for the threshold binarizer.
package threshold_pkg;

  // Threshold loaded into both pending and active registers on reset.
  localparam logic [7:0] DEFAULT_RESET_THRESHOLD = 8'd128;

  // BT.601-style luma weights scaled by 256 (77 + 150 + 29 = 256).
  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  // Register stages inside rgb565_to_luma.
  localparam int unsigned LUMA_LATENCY = 2;

  typedef struct packed {
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
  } rgb565_t;

  // Bit replication so full-scale 5/6-bit codes map to 255.
  function automatic logic [7:0] expand5(input logic [4:0] v);
    return {v, v[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] v);
    return {v, v[5:4]};
  endfunction

endpackage

// File: rtl/rgb565_to_luma.sv
// Two-stage RGB565 -> 8-bit luma converter with valid/sof sideband.
// Stage 1 expands channels and multiplies, stage 2 sums and drops the fraction.
module rgb565_to_luma
  import threshold_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  rgb565_t    pixel_i,
  input  logic       valid_i,
  input  logic       sof_i,
  output logic [7:0] luma_o,
  output logic       valid_o,
  output logic       sof_o
);

  logic [15:0] prod_r_d, prod_r_q;
  logic [15:0] prod_g_d, prod_g_q;
  logic [15:0] prod_b_d, prod_b_q;
  logic        s1_valid_d, s1_valid_q;
  logic        s1_sof_d, s1_sof_q;

  logic [15:0] sum;
  logic [7:0]  luma_d, luma_q;
  logic        s2_valid_d, s2_valid_q;
  logic        s2_sof_d, s2_sof_q;

  // Stage 1 next state: products update only for valid pixels, sideband always advances.
  always_comb begin
    prod_r_d   = prod_r_q;
    prod_g_d   = prod_g_q;
    prod_b_d   = prod_b_q;
    s1_valid_d = valid_i;
    s1_sof_d   = valid_i & sof_i;
    if (valid_i) begin
      prod_r_d = {8'd0, COEF_R} * {8'd0, expand5(pixel_i.r5)};
      prod_g_d = {8'd0, COEF_G} * {8'd0, expand6(pixel_i.g6)};
      prod_b_d = {8'd0, COEF_B} * {8'd0, expand5(pixel_i.b5)};
    end
  end

  // Stage 2 next state: weights sum to 256, so the 16-bit sum tops out at 65280.
  always_comb begin
    sum        = prod_r_q + prod_g_q + prod_b_q;
    luma_d     = luma_q;
    s2_valid_d = s1_valid_q;
    s2_sof_d   = s1_sof_q;
    if (s1_valid_q) begin
      luma_d = 8'(sum >> 8);
    end
  end

  // Pipeline registers for both stages.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_r_q   <= '0;
      prod_g_q   <= '0;
      prod_b_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      luma_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_sof_q   <= 1'b0;
    end else begin
      prod_r_q   <= prod_r_d;
      prod_g_q   <= prod_g_d;
      prod_b_q   <= prod_b_d;
      s1_valid_q <= s1_valid_d;
      s1_sof_q   <= s1_sof_d;
      luma_q     <= luma_d;
      s2_valid_q <= s2_valid_d;
      s2_sof_q   <= s2_sof_d;
    end
  end

  assign luma_o  = luma_q;
  assign valid_o = s2_valid_q;
  assign sof_o   = s2_sof_q;

endmodule

// File: rtl/threshold_binarizer.sv
// Binarizes an RGB565 stream against a threshold that only changes at frame start.
// Optional per-frame white-pixel statistics when THRESHOLD_STATS_EN is defined.
module threshold_binarizer #(
  parameter logic [7:0] RESET_THRESHOLD = threshold_pkg::DEFAULT_RESET_THRESHOLD
`ifdef THRESHOLD_STATS_EN
  ,
  parameter int unsigned CNT_W = 17
`endif
) (
  input  logic              clk_in,
  input  logic              rst_in_n,
  input  logic [7:0]        threshold_in,
  input  logic              valid_threshold_in,
  output logic [7:0]        threshold_cur_out,
  input  logic [15:0]       pixel_in,
  input  logic              pixel_valid_in,
  input  logic              frame_start_in,
  output logic [15:0]       pixel_out,
  output logic              binary_out,
  output logic              pixel_valid_out,
  output logic              frame_start_out
`ifdef THRESHOLD_STATS_EN
  ,
  output logic [CNT_W-1:0]  ones_count_out,
  output logic              stats_valid_out
`endif
);

  import threshold_pkg::*;

  logic [7:0] luma;
  logic       luma_valid;
  logic       luma_sof;

  rgb565_to_luma u_luma (
    .clk_i   (clk_in),
    .rst_ni  (rst_in_n),
    .pixel_i (rgb565_t'(pixel_in)),
    .valid_i (pixel_valid_in),
    .sof_i   (frame_start_in),
    .luma_o  (luma),
    .valid_o (luma_valid),
    .sof_o   (luma_sof)
  );

  logic [7:0] pending_d, pending_q;
  logic [7:0] active_d, active_q;
  logic [7:0] thr_eff;
  logic       commit;
  logic       white;
  logic       binary_d, binary_q;
  logic       valid_d, valid_q;
  logic       sof_d, sof_q;

  // Threshold staging and S3 compare; a sof pixel in S3 commits pending and uses it directly.
  always_comb begin
    commit    = luma_valid & luma_sof;
    thr_eff   = commit ? pending_q : active_q;
    white     = (luma >= thr_eff);
    pending_d = valid_threshold_in ? threshold_in : pending_q;
    active_d  = commit ? pending_q : active_q;
    valid_d   = luma_valid;
    sof_d     = commit;
    binary_d  = luma_valid ? white : binary_q;
  end

  // Threshold registers and S3 output registers.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      pending_q <= RESET_THRESHOLD;
      active_q  <= RESET_THRESHOLD;
      binary_q  <= 1'b0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      active_q  <= active_d;
      binary_q  <= binary_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
    end
  end

  assign threshold_cur_out = pending_q;
  assign pixel_out         = {16{binary_q}};
  assign binary_out        = binary_q;
  assign pixel_valid_out   = valid_q;
  assign frame_start_out   = sof_q;

`ifdef THRESHOLD_STATS_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] ones_d, ones_q;
  logic             stats_valid_d, stats_valid_q;

  // Per-frame white counter; a sof pixel publishes the previous total and restarts the count.
  always_comb begin
    cnt_d         = cnt_q;
    ones_d        = ones_q;
    stats_valid_d = 1'b0;
    if (commit) begin
      ones_d        = cnt_q;
      stats_valid_d = 1'b1;
      cnt_d         = {{(CNT_W-1){1'b0}}, white};
    end else if (luma_valid && white && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      cnt_q         <= '0;
      ones_q        <= '0;
      stats_valid_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      ones_q        <= ones_d;
      stats_valid_q <= stats_valid_d;
    end
  end

  assign ones_count_out  = ones_q;
  assign stats_valid_out = stats_valid_q;
`endif

endmodule
